// File: rtl/ddr2_rst_sequencer.sv
// Reset sequencer for the DDR2 clocking block: pulses the PLL reset, debounces lock, then releases channel resets in staggered order.
// Inputs see 2 flops of synchronizer latency and every output is registered; no flow control, and a lost lock or ready re-runs the sequence.
module ddr2_rst_sequencer #(
  parameter int                 NUM_RST       = 4,
  parameter logic [NUM_RST-1:0] IDLY_MASK     = 4'b1110,
  parameter int                 PLL_RST_CYC   = 8,
  parameter int                 LOCK_DEBOUNCE = 16,
  parameter int                 LOCK_TIMEOUT  = 4096,
  parameter int                 MAX_RETRY     = 3,
  parameter int                 RST_SYNC_NUM  = 25,
  parameter int                 STAGGER       = 4
) (
  input  logic                clk0,
  input  logic                rst0,
  input  logic                pll_locked,
  input  logic                idelay_ctrl_rdy,
  output logic                pll_rst,
  output logic [NUM_RST-1:0]  rst_out,
  output logic                init_done,
  output logic                fail,
  output logic [((MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1)-1:0] retry_cnt,
  output logic                lock_lost
);

  localparam int RTY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  localparam int P_A  = (PLL_RST_CYC  > LOCK_DEBOUNCE) ? PLL_RST_CYC  : LOCK_DEBOUNCE;
  localparam int P_B  = (LOCK_TIMEOUT > RST_SYNC_NUM)  ? LOCK_TIMEOUT : RST_SYNC_NUM;
  localparam int P_C  = (P_A > P_B) ? P_A : P_B;
  localparam int PMAX = (P_C > STAGGER) ? P_C : STAGGER;
  localparam int CNT_W = $clog2(PMAX + 1);

  localparam logic [CNT_W-1:0] C_PLL  = CNT_W'(PLL_RST_CYC);
  localparam logic [CNT_W-1:0] C_DEB  = CNT_W'(LOCK_DEBOUNCE);
  localparam logic [CNT_W-1:0] C_TMO  = CNT_W'(LOCK_TIMEOUT);
  localparam logic [CNT_W-1:0] C_SYNC = CNT_W'(RST_SYNC_NUM);
  localparam logic [CNT_W-1:0] C_STG  = CNT_W'(STAGGER);
  localparam logic [RTY_W-1:0] RTY_MAX = RTY_W'(MAX_RETRY);

  localparam logic [2:0] S_PLL_RST   = 3'd0;
  localparam logic [2:0] S_WAIT_LOCK = 3'd1;
  localparam logic [2:0] S_HOLD      = 3'd2;
  localparam logic [2:0] S_WAIT_RDY  = 3'd3;
  localparam logic [2:0] S_RELEASE   = 3'd4;
  localparam logic [2:0] S_RUN       = 3'd5;
  localparam logic [2:0] S_FAIL      = 3'd6;

  logic               lock_meta_q, lock_meta_d, lock_s_q, lock_s_d;
  logic               rdy_meta_q, rdy_meta_d, rdy_s_q, rdy_s_d;
  logic [2:0]         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d, deb_q, deb_d;
  logic               pll_rst_q, pll_rst_d;
  logic [NUM_RST-1:0] rst_out_q, rst_out_d;
  logic               init_done_q, init_done_d;
  logic               fail_q, fail_d;
  logic [RTY_W-1:0]   retry_q, retry_d;
  logic               lock_lost_q, lock_lost_d;

  logic [CNT_W-1:0]   cnt_inc, deb_inc;
  logic [NUM_RST-1:0] pend, low_bit;
  logic               last_pend, lock_loss, rdy_loss;

  always_comb begin
    lock_meta_d = pll_locked;
    lock_s_d    = lock_meta_q;
    rdy_meta_d  = idelay_ctrl_rdy;
    rdy_s_d     = rdy_meta_q;
  end

  // Counters saturate at all-ones instead of wrapping.
  always_comb begin
    cnt_inc   = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);
    deb_inc   = (deb_q == {CNT_W{1'b1}}) ? deb_q : deb_q + CNT_W'(1);
    pend      = rst_out_q & IDLY_MASK;
    low_bit   = pend & (~pend + NUM_RST'(1));
    last_pend = ((pend & ~low_bit) == '0);
    lock_loss = !lock_s_q &&
                (state_q inside {S_HOLD, S_WAIT_RDY, S_RELEASE, S_RUN});
    rdy_loss  = lock_s_q && !rdy_s_q && (IDLY_MASK != '0) &&
                (state_q inside {S_RELEASE, S_RUN});
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    deb_d       = deb_q;
    pll_rst_d   = pll_rst_q;
    rst_out_d   = rst_out_q;
    init_done_d = init_done_q;
    fail_d      = fail_q;
    retry_d     = retry_q;
    lock_lost_d = 1'b0;

    if (lock_loss) begin
      state_d     = S_PLL_RST;
      cnt_d       = '0;
      deb_d       = '0;
      pll_rst_d   = 1'b1;
      rst_out_d   = '1;
      init_done_d = 1'b0;
      lock_lost_d = 1'b1;
    end else if (rdy_loss) begin
      // Only the IDELAYCTRL-gated channels go back into reset.
      state_d     = S_WAIT_RDY;
      cnt_d       = '0;
      rst_out_d   = rst_out_q | IDLY_MASK;
      init_done_d = 1'b0;
      lock_lost_d = 1'b1;
    end else begin
      case (state_q)
        S_PLL_RST: begin
          pll_rst_d = 1'b1;
          rst_out_d = '1;
          deb_d     = '0;
          if (cnt_inc >= C_PLL) begin
            state_d   = S_WAIT_LOCK;
            pll_rst_d = 1'b0;
            cnt_d     = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end

        S_WAIT_LOCK: begin
          deb_d = lock_s_q ? deb_inc : '0;
          if (lock_s_q && (deb_inc >= C_DEB)) begin
            state_d = S_HOLD;
            cnt_d   = '0;
            deb_d   = '0;
          end else if (cnt_inc >= C_TMO) begin
            cnt_d     = '0;
            deb_d     = '0;
            pll_rst_d = 1'b1;
            if (retry_q == RTY_MAX) begin
              state_d = S_FAIL;
              fail_d  = 1'b1;
            end else begin
              state_d = S_PLL_RST;
              retry_d = retry_q + RTY_W'(1);
            end
          end else begin
            cnt_d = cnt_inc;
          end
        end

        S_HOLD: begin
          if (cnt_inc >= C_SYNC) begin
            state_d   = S_WAIT_RDY;
            cnt_d     = '0;
            rst_out_d = rst_out_q & IDLY_MASK;
          end else begin
            cnt_d = cnt_inc;
          end
        end

        S_WAIT_RDY: begin
          if (IDLY_MASK == '0) begin
            state_d     = S_RUN;
            init_done_d = 1'b1;
            retry_d     = '0;
          end else if (rdy_s_q) begin
            // The cycle that observes ready counts as the first stagger cycle.
            state_d = S_RELEASE;
            cnt_d   = CNT_W'(1);
          end
        end

        S_RELEASE: begin
          if (cnt_inc >= C_STG) begin
            cnt_d     = '0;
            rst_out_d = rst_out_q & ~low_bit;
            if (last_pend) begin
              state_d     = S_RUN;
              init_done_d = 1'b1;
              retry_d     = '0;
            end
          end else begin
            cnt_d = cnt_inc;
          end
        end

        S_RUN: begin
          init_done_d = 1'b1;
        end

        S_FAIL: begin
          pll_rst_d = 1'b1;
          rst_out_d = '1;
          fail_d    = 1'b1;
        end

        default: begin
          state_d   = S_PLL_RST;
          cnt_d     = '0;
          pll_rst_d = 1'b1;
          rst_out_d = '1;
        end
      endcase
    end
  end

  always_ff @(posedge clk0) begin
    if (rst0) begin
      lock_meta_q <= 1'b0;
      lock_s_q    <= 1'b0;
      rdy_meta_q  <= 1'b0;
      rdy_s_q     <= 1'b0;
      state_q     <= S_PLL_RST;
      cnt_q       <= '0;
      deb_q       <= '0;
      pll_rst_q   <= 1'b1;
      rst_out_q   <= '1;
      init_done_q <= 1'b0;
      fail_q      <= 1'b0;
      retry_q     <= '0;
      lock_lost_q <= 1'b0;
    end else begin
      lock_meta_q <= lock_meta_d;
      lock_s_q    <= lock_s_d;
      rdy_meta_q  <= rdy_meta_d;
      rdy_s_q     <= rdy_s_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      deb_q       <= deb_d;
      pll_rst_q   <= pll_rst_d;
      rst_out_q   <= rst_out_d;
      init_done_q <= init_done_d;
      fail_q      <= fail_d;
      retry_q     <= retry_d;
      lock_lost_q <= lock_lost_d;
    end
  end

  assign pll_rst   = pll_rst_q;
  assign rst_out   = rst_out_q;
  assign init_done = init_done_q;
  assign fail      = fail_q;
  assign retry_cnt = retry_q;
  assign lock_lost = lock_lost_q;

endmodule
